// File: rtl/tdm_slot_sequencer_pkg.sv
// Shared constants and state encoding for the TDM slot sequencer.
// The inactive level matches the idle-high outputs of the downstream distributor.
package tdm_slot_sequencer_pkg;

   localparam int NUM_SLOTS = 8;
   localparam int SEL_W     = 3;
   localparam int WORD_W    = 8;
   localparam int CNT_W     = 8;

   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Select value of the final slot in a frame.
   function automatic logic is_last_slot(input logic [SEL_W-1:0] sel);
      return (sel == SEL_W'(NUM_SLOTS - 1));
   endfunction

endpackage

// File: rtl/tdm_slot_sequencer_if.sv
// Upstream word handshake plus the serial/select bundle toward the distributor.
// The sequencer sits on the slave side; whoever feeds words uses the master side.
interface tdm_slot_sequencer_if;
   import tdm_slot_sequencer_pkg::*;

   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic [SEL_W-1:0]  sel;
   logic              ser_data;
   logic              slot_strobe;
   logic              frame_active;
   logic              frame_done;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  sel,
      input  ser_data,
      input  slot_strobe,
      input  frame_active,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output sel,
      output ser_data,
      output slot_strobe,
      output frame_active,
      output frame_done
   );

endinterface

// File: rtl/tdm_slot_sequencer_slot_timer.sv
// Wrapping up-counter flagging the last cycle of a LIMIT-cycle period.
// Shared by slot timing and inter-frame gap timing.
module tdm_slot_sequencer_slot_timer
   import tdm_slot_sequencer_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_r;

   assign last = (cnt_r == LAST_VAL);

   // Period counter: load restarts the period, wrap happens on the last cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         if (last) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/tdm_slot_sequencer.sv
// Latches an 8-bit word and serialises it LSB first, one bit per slot,
// driving the distributor select in lock-step with the serial bit.
module tdm_slot_sequencer
   import tdm_slot_sequencer_pkg::*;
#(
   parameter int SLOT_CYCLES = 4,
   parameter int FRAME_GAP   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tdm_slot_sequencer_if.slave  bus
);

   // A zero gap never enters GAP, but the timer still needs a legal period.
   localparam int GAP_LIMIT = (FRAME_GAP > 0) ? FRAME_GAP : 1;

   state_t            state_r;
   logic [WORD_W-1:0] buf_r;
   logic [SEL_W-1:0]  sel_r;
   logic              ser_r;
   logic              strobe_r;
   logic              active_r;
   logic              done_r;

   logic              take_s;
   logic              slot_en_s;
   logic              gap_en_s;
   logic              slot_last_s;
   logic              gap_last_s;
   logic              frame_end_s;
   logic [SEL_W-1:0]  next_sel_s;

   assign take_s      = (state_r == IDLE) && bus.in_valid;
   assign slot_en_s   = (state_r == SEND);
   assign gap_en_s    = (state_r == GAP);
   assign frame_end_s = slot_en_s && slot_last_s && is_last_slot(sel_r);
   assign next_sel_s  = sel_r + SEL_W'(1);

   tdm_slot_sequencer_slot_timer #(.LIMIT(SLOT_CYCLES)) u_slot_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (take_s),
      .enable (slot_en_s),
      .last   (slot_last_s)
   );

   tdm_slot_sequencer_slot_timer #(.LIMIT(GAP_LIMIT)) u_gap_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (frame_end_s),
      .enable (gap_en_s),
      .last   (gap_last_s)
   );

   // Frame sequencer: sel and ser_data always update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         buf_r    <= {WORD_W{1'b0}};
         sel_r    <= {SEL_W{1'b0}};
         ser_r    <= IDLE_LEVEL;
         strobe_r <= 1'b0;
         active_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         strobe_r <= 1'b0;
         done_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  buf_r    <= bus.in_data;
                  sel_r    <= {SEL_W{1'b0}};
                  ser_r    <= bus.in_data[0];
                  strobe_r <= 1'b1;
                  active_r <= 1'b1;
                  state_r  <= SEND;
               end else begin
                  state_r  <= IDLE;
               end
            end
            SEND: begin
               if (slot_last_s && !is_last_slot(sel_r)) begin
                  sel_r    <= next_sel_s;
                  ser_r    <= buf_r[next_sel_s];
                  strobe_r <= 1'b1;
               end else if (slot_last_s) begin
                  sel_r    <= {SEL_W{1'b0}};
                  ser_r    <= IDLE_LEVEL;
                  active_r <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= (FRAME_GAP > 0) ? GAP : IDLE;
               end else begin
                  state_r  <= SEND;
               end
            end
            GAP: begin
               if (gap_last_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= GAP;
               end
            end
            default: begin
               state_r  <= IDLE;
               sel_r    <= {SEL_W{1'b0}};
               ser_r    <= IDLE_LEVEL;
               active_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = (state_r == IDLE);
   assign bus.sel          = sel_r;
   assign bus.ser_data     = ser_r;
   assign bus.slot_strobe  = strobe_r;
   assign bus.frame_active = active_r;
   assign bus.frame_done   = done_r;

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Directed bench for tdm_slot_sequencer with a cycle-position reference model
// and a simple idle-high distributor model on the default-parameter instance.
module tb_tdm_slot_sequencer;
   import tdm_slot_sequencer_pkg::*;

   localparam int SC_A = 4, GAP_A = 2;
   localparam int SC_B = 1, GAP_B = 0;
   localparam int K_MAX = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tdm_slot_sequencer_if ifa ();
   tdm_slot_sequencer_if ifb ();

   tdm_slot_sequencer #(.SLOT_CYCLES(SC_A), .FRAME_GAP(GAP_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   tdm_slot_sequencer #(.SLOT_CYCLES(SC_B), .FRAME_GAP(GAP_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_a[$];
   int acc_b[$];

   // Model state: k = cycles since the accepting edge (1 = first slot cycle), 0 = none yet.
   int ka = 0, kb = 0;
   logic [7:0] wa = 8'h00, wb = 8'h00;

   // Expected {in_ready, frame_done, frame_active, slot_strobe, ser_data, sel[2:0]}.
   function automatic logic [7:0] expect_out(input int k, input int sc, input int gap,
                                             input logic [7:0] w);
      logic [7:0] e;
      int slot;
      e = 8'b1000_1000;
      if (k >= 1 && k <= 8*sc) begin
         slot   = (k - 1) / sc;
         e[2:0] = 3'(slot);
         e[3]   = w[slot];
         e[4]   = ((k - 1) % sc == 0);
         e[5]   = 1'b1;
      end
      if (k == 8*sc + 1) e[6] = 1'b1;
      if (k >= 1 && k <= 8*sc + gap) e[7] = 1'b0;
      return e;
   endfunction

   function automatic logic [7:0] dist_expect(input int k, input int sc, input logic [7:0] w);
      logic [7:0] d;
      int slot;
      d = 8'hFF;
      if (k >= 1 && k <= 8*sc) begin
         slot    = (k - 1) / sc;
         d[slot] = w[slot];
      end
      return d;
   endfunction

   function automatic logic [7:0] dist_of(input logic [2:0] s, input logic b);
      logic [7:0] d;
      d    = 8'hFF;
      d[s] = b;
      return d;
   endfunction

   function automatic bit busy(input int k, input int sc, input int gap);
      return (k >= 1 && k <= 8*sc + gap);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   // Reference model advance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ka <= 0;
         kb <= 0;
      end else begin
         if (!busy(ka, SC_A, GAP_A) && ifa.in_valid) begin
            ka <= 1;
            wa <= ifa.in_data;
         end else if (ka != 0 && ka < K_MAX) begin
            ka <= ka + 1;
         end
         if (!busy(kb, SC_B, GAP_B) && ifb.in_valid) begin
            kb <= 1;
            wb <= ifb.in_data;
         end else if (kb != 0 && kb < K_MAX) begin
            kb <= kb + 1;
         end
      end
   end

   // Per-cycle comparison against the model plus acceptance logging.
   always @(negedge clk) begin : cmp
      logic [7:0] act;
      cyc <= cyc + 1;
      if (rst_n && ifa.in_valid && ifa.in_ready) acc_a.push_back(cyc);
      if (rst_n && ifb.in_valid && ifb.in_ready) acc_b.push_back(cyc);
      act = {ifa.in_ready, ifa.frame_done, ifa.frame_active, ifa.slot_strobe, ifa.ser_data, ifa.sel};
      chk("cycle_a", act, expect_out(ka, SC_A, GAP_A, wa));
      act = {ifb.in_ready, ifb.frame_done, ifb.frame_active, ifb.slot_strobe, ifb.ser_data, ifb.sel};
      chk("cycle_b", act, expect_out(kb, SC_B, GAP_B, wb));
      chk("dist_a", dist_of(ifa.sel, ifa.ser_data), dist_expect(ka, SC_A, wa));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] bits;
      int sels_ok, done_at, done_cnt, low_cnt, ones, st;
      ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
      ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
      repeat (3) step();
      chk("reset_outs_a", {ifa.in_ready, ifa.frame_done, ifa.frame_active, ifa.slot_strobe,
                           ifa.ser_data, ifa.sel}, 8'b1000_1000);
      rst_n = 1'b1;

      // 1: single frame of 8'hA5
      ifa.in_valid = 1'b1; ifa.in_data = 8'hA5;
      step();
      ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
      bits = 8'h00; sels_ok = 1; done_at = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n <= 32 && ifa.slot_strobe) bits[ifa.sel] = ifa.ser_data;
         if (n <= 32 && ifa.sel != 3'((n - 1) / 4)) sels_ok = 0;
         if (ifa.frame_done && done_at == 0) done_at = n;
         step();
      end
      chk("t1_bits", bits, 8'hA5);
      chk("t1_sel_steps", sels_ok, 1);
      chk("t1_done_at", done_at, 33);

      // 2: back-to-back words with in_valid held high
      acc_a.delete();
      low_cnt = 0;
      ifa.in_valid = 1'b1; ifa.in_data = 8'h3C;
      step();
      ifa.in_data = 8'hC3;
      for (int n = 1; n <= 35; n++) begin
         if (!ifa.in_ready) low_cnt++;
         step();
      end
      ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
      chk("t2_ready_low", low_cnt, 34);
      chk("t2_acc_count", acc_a.size(), 2);
      if (acc_a.size() >= 2) chk("t2_acc_spacing", acc_a[1] - acc_a[0], 35);
      repeat (40) step();

      // 3 + 6: zero word, input changes mid-frame, distributor view
      ifa.in_valid = 1'b1; ifa.in_data = 8'h00;
      step();
      ifa.in_valid = 1'b0;
      ones = 0;
      for (int n = 1; n <= 32; n++) begin
         if (n == 10) ifa.in_data = 8'hFF;
         if (ifa.frame_active && ifa.ser_data) ones++;
         if (n == 14) chk("t6_dist_slot3", dist_of(ifa.sel, ifa.ser_data), 8'hF7);
         step();
      end
      chk("t3_ones", ones, 0);
      repeat (6) step();
      chk("t6_dist_idle", dist_of(ifa.sel, ifa.ser_data), 8'hFF);
      ifa.in_data = 8'h00;

      // 4: asynchronous reset during slot 4, in_valid high across release
      ifa.in_valid = 1'b1; ifa.in_data = 8'h5A;
      step();
      ifa.in_valid = 1'b0;
      for (int n = 1; n < 18; n++) step();
      chk("t4_in_slot4", ifa.sel, 3'd4);
      #2;
      rst_n = 1'b0;
      ifa.in_valid = 1'b1; ifa.in_data = 8'h77;
      #1;
      chk("t4_async_clear", {ifa.sel, ifa.ser_data, ifa.frame_active, ifa.frame_done},
          {3'd0, 1'b1, 1'b0, 1'b0});
      repeat (2) step();
      rst_n = 1'b1;
      chk("t4_ready_after", ifa.in_ready, 1'b1);
      step();
      ifa.in_valid = 1'b0;
      chk("t4_restart", {ifa.frame_active, ifa.ser_data, ifa.sel}, {1'b1, 1'b1, 3'd0});
      done_at = 0; done_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         if (ifa.frame_done) begin
            done_cnt++;
            if (done_at == 0) done_at = n;
         end
         step();
      end
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_done_at", done_at, 33);

      // 5: one-cycle slots, no gap
      acc_b.delete();
      ifb.in_valid = 1'b1; ifb.in_data = 8'h81;
      step();
      bits = 8'h00; st = 0;
      for (int n = 1; n <= 9; n++) begin
         if (n <= 8) bits[n - 1] = ifb.ser_data;
         if (ifb.slot_strobe) st++;
         step();
      end
      ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
      chk("t5_bits", bits, 8'h81);
      chk("t5_strobes", st, 8);
      chk("t5_acc_count", acc_b.size(), 2);
      if (acc_b.size() >= 2) chk("t5_acc_spacing", acc_b[1] - acc_b[0], 9);
      repeat (12) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tdm_slot_sequencer.md
Name: tdm_slot_sequencer

Overview:
Upstream feeder for the 8-channel data distributor (3-bit select, 1-bit data, idle-high outputs).
- Accepts 8-bit parallel words over a valid/ready handshake.
- Latches each word and time-division sequences it onto one serial line, one bit per slot, LSB first.
- Drives the distributor's select inputs in step: channel k carries bit k.

Parameters:
SLOT_CYCLES, 4, clock cycles per slot; legal range 1..255
FRAME_GAP, 2, idle cycles forced between frames; legal range 0..255

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  8  word to distribute; bit k goes to channel k
in_ready  output  1  high only in IDLE; a transfer occurs when in_valid && in_ready at a rising edge
sel  output  3  channel select to the distributor; MSB maps to A, LSB to C
ser_data  output  1  serial bit to the distributor; 1 when not sending
slot_strobe  output  1  one-cycle pulse in the first cycle of each slot
frame_active  output  1  high during all slots of a frame
frame_done  output  1  one-cycle pulse in the first cycle after slot 7 ends

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; all flops clear immediately on rst_n low.
- Reset values: state=IDLE, sel=0, ser_data=1, slot_strobe=0, frame_active=0, frame_done=0, word buffer=8'h00, counters=0. in_ready=1 after reset (decoded from IDLE).
- States:
  - IDLE: in_ready=1, sel=0, ser_data=1.
    - On transfer: buf<=in_data, sel<=0, ser_data<=in_data[0], slot_cnt<=0, slot_strobe<=1, frame_active<=1, go to SEND.
  - SEND: slot_cnt increments each cycle. slot_strobe=0 except in the first cycle of a slot.
    - At slot_cnt==SLOT_CYCLES-1 with sel<7: sel<=sel+1, ser_data<=buf[sel+1], slot_cnt<=0, slot_strobe<=1.
    - At slot_cnt==SLOT_CYCLES-1 with sel==7: sel<=0, ser_data<=1, frame_active<=0, frame_done<=1 for one cycle.
      - Next state is GAP if FRAME_GAP>0, else IDLE.
  - GAP: in_ready=0, outputs idle. Counts FRAME_GAP cycles, then goes to IDLE.
- Latency and timing:
  - The first slot is visible in the cycle after the accepting edge.
  - Each slot lasts exactly SLOT_CYCLES cycles; the frame occupies 8*SLOT_CYCLES cycles.
  - With in_valid held high, successive acceptances are 8*SLOT_CYCLES+FRAME_GAP+1 cycles apart.
- in_data and in_valid are ignored outside IDLE. The buffer is stable for the whole frame.
- SLOT_CYCLES=1: sel advances every cycle and slot_strobe stays high for 8 consecutive cycles.
- sel and ser_data change on the same edge, so the distributor never sees a bit on the wrong channel.
- Reset mid-frame: the frame is discarded and no frame_done is issued. After release, operation restarts from IDLE.
- in_valid asserted during the same cycle rst_n deasserts: no transfer until the first rising edge with rst_n high.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, SEND=2'd1, GAP=2'd2
  - NUM_SLOTS=8 and SEL_W=3
  - IDLE_LEVEL=1'b1, the distributor's inactive level
- One natural sub-module: slot_timer, a parameterised down/up counter.
  - Inputs: clk, rst_n, load, enable.
  - Output: a last-cycle flag.
  - Reused for both slot timing and GAP timing.

Test Plan (SLOT_CYCLES=4, FRAME_GAP=2 unless noted):
1. Reset then send 8'hA5 -> sel steps 0..7, 4 cycles each; ser_data is 1,0,1,0,0,1,0,1; frame_done pulses 33 cycles after the accepting edge.
2. in_valid held high with words 8'h3C then 8'hC3 -> second acceptance exactly 35 cycles after the first; in_ready is low for 34 cycles in between.
3. Change in_data to 8'hFF in mid-frame after accepting 8'h00 -> ser_data stays 0 in all 8 slots.
4. Pull rst_n low during slot 4 -> sel=0, ser_data=1, frame_active=0 immediately with no clock edge; no frame_done; in_ready=1 after release.
5. SLOT_CYCLES=1, FRAME_GAP=0, send 8'h81 -> ser_data is 1,0,0,0,0,0,0,1 on consecutive cycles; slot_strobe high for 8 cycles; next acceptance possible 9 cycles later.
6. With the distributor attached, send 8'h00 -> distributor output bit k is 0 only during slot k and 1 elsewhere; all outputs are 8'hFF when idle.
